// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: R-type funct codes for the
// mult/div group, the controller state encoding and a long-op decode helper.
package muldiv_pkg;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    // True for the functs that run the multi-cycle datapath.
    function automatic logic is_long(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
//   div_mode : 0 = shift-add multiply step, 1 = restoring shift-subtract step
//   acc      : 2*WIDTH working register
//              multiply: {partial product, remaining multiplier bits}
//              divide  : {partial remainder, remaining dividend / quotient bits}
//   opnd     : multiplicand (multiply) or divisor (divide), both magnitudes
//   acc_next : working register after this step
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // Multiply: add multiplicand if the current multiplier bit is set,
        // then shift the whole accumulator right, keeping the carry.
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: remainder shifted left with the next dividend bit appended.
        // It is below 2*divisor, so the W-bit difference is exact when ge.
        trial = acc[2*WIDTH-1:WIDTH-1];
        ge    = trial >= {1'b0, opnd};
        diff  = trial[WIDTH-1:0] - opnd;
        if (div_mode)
            acc_next = {(ge ? diff : trial[WIDTH-1:0]), acc[WIDTH-2:0], ge};
        else
            acc_next = {sum, acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
//   clk, reset  : clock, synchronous active-high reset
//   start/funct : request and R-type funct (mult/multu/div/divu/mthi/mtlo/mfhi/mflo)
//   a, b        : rs / rt operands
//   busy        : long operation in progress (stall the PC)
//   done        : one-cycle pulse, HI/LO hold the new result
//   div_by_zero : pulses with done for div/divu with b == 0
//   hi, lo      : HI/LO registers
//   result      : hi for mfhi, lo for mflo, else 0
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, neg_q, neg_r, dbz;

    logic               accept, sgn;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;

    assign accept = (state == IDLE) && start && is_long(funct);
    assign sgn    = (funct == F_MULT) || (funct == F_DIV);
    assign a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
    assign quo    = acc[WIDTH-1:0];
    assign rem    = acc[2*WIDTH-1:WIDTH];
    assign busy   = (state != IDLE);

    always_comb begin
        result = '0;
        if (funct == F_MFHI)      result = hi;
        else if (funct == F_MFLO) result = lo;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (cnt == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_next;
            done        <= (state == FIX);
            div_by_zero <= (state == FIX) && is_div && dbz;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div <= funct[1];
                        opnd   <= b_mag;
                        acc    <= {{WIDTH{1'b0}}, a_mag};
                        neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= sgn && a[WIDTH-1];
                        dbz    <= (b == '0);
                        cnt    <= CW'(WIDTH - 1);
                    end else if (start && funct == F_MTHI) begin
                        hi <= a;
                    end else if (start && funct == F_MTLO) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        // Remainder follows the dividend sign; a zero divisor
                        // keeps the raw all-ones quotient.
                        hi <= neg_r ? -rem : rem;
                        lo <= (neg_q && !dbz) ? -quo : quo;
                    end else begin
                        {hi, lo} <= neg_q ? -acc : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo, result;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .funct       (funct),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one long op; returns in the done cycle (or after the bound).
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int nbusy, output logic dbz_done);
        start = 1'b1; funct = f; a = x; b = y;
        tick();
        start = 1'b0;
        lat = 1; nbusy = 0;
        while (!done && lat < 60) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        dbz_done = div_by_zero;
    endtask

    int   lat, nb;
    logic dz, seen;

    initial begin
        reset = 1'b1; start = 1'b0; funct = '0; a = '0; b = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz",  64'(div_by_zero), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);

        // 1. signed multiply -3 * 7
        run_op(F_MULT, 32'hFFFFFFFD, 32'h00000007, lat, nb, dz);
        check("mult_lat",  64'(lat), 64'd34);
        check("mult_busy", 64'(nb), 64'd33);
        check("mult_busy_at_done", 64'(busy), 64'd0);
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        check("mult_dbz",  64'(dz), 64'd0);

        // 2. unsigned max * max
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, nb, dz);
        check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

        // 3. signed divides
        run_op(F_DIV, 32'hFFFFFFF9, 32'h00000002, lat, nb, dz);
        check("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        check("div_neg_lat", 64'(lat), 64'd34);
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat, nb, dz);
        check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);
        check("div_ovf_dbz", 64'(dz), 64'd0);

        // 4. unsigned divide by zero
        run_op(F_DIVU, 32'h00000005, 32'h00000000, lat, nb, dz);
        check("divz_hilo", {hi, lo}, 64'h00000005_FFFFFFFF);
        check("divz_dbz_done", 64'(dz), 64'd1);
        tick();
        check("divz_dbz_after", 64'(div_by_zero), 64'd0);
        check("divz_done_after", 64'(done), 64'd0);

        // 5a. start while busy is ignored
        start = 1'b1; funct = F_MULT; a = 32'd3; b = 32'd5;
        tick();                                   // N+1
        start = 1'b0;
        tick(); tick(); tick(); tick();           // N+5
        start = 1'b1; funct = F_DIV; a = 32'd100; b = 32'd7;
        tick();                                   // N+6
        start = 1'b0;
        lat = 6;
        while (!done && lat < 60) begin tick(); lat++; end
        check("ign_lat",  64'(lat), 64'd34);
        check("ign_hilo", {hi, lo}, 64'h00000000_0000000F);

        // 5b. reset mid-operation
        start = 1'b1; funct = F_MULT; a = 32'd9; b = 32'd9;
        tick();                                   // N+1
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();       // N+10
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | done | busy;
            tick();
        end
        check("abort_no_done", 64'(seen), 64'd0);

        // 5c. fresh multu after reset
        run_op(F_MULTU, 32'd6, 32'd7, lat, nb, dz);
        check("fresh_lat",  64'(lat), 64'd34);
        check("fresh_hilo", {hi, lo}, 64'h00000000_0000002A);

        // 6a. register moves
        start = 1'b1; funct = F_MTHI; a = 32'h00001234;
        check("mthi_busy_req", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_busy", 64'(busy), 64'd0);
        funct = F_MFHI; #1;
        check("mfhi_result", 64'(result), 64'h1234);
        start = 1'b1; funct = F_MTLO; a = 32'h0000ABCD;
        tick();
        start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'hABCD);
        check("mtlo_hi_kept", 64'(hi), 64'h1234);
        funct = F_MFLO; #1;
        check("mflo_result", 64'(result), 64'hABCD);
        funct = F_MULT; #1;
        check("other_result", 64'(result), 64'd0);

        // 6b. back-to-back: second start lands in the first done cycle
        run_op(F_MULTU, 32'd2, 32'd3, lat, nb, dz);
        check("b2b_first_lo", 64'(lo), 64'd6);
        run_op(F_MULTU, 32'd4, 32'd5, lat, nb, dz);
        check("b2b_lat",  64'(lat), 64'd34);
        check("b2b_hilo", {hi, lo}, 64'h00000000_00000014);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO registers for the single-cycle MIPS datapath. It extends ALU function decoding to the R-type mult/div group and executes those operations over multiple cycles behind a start/busy/done handshake. The controller stalls the PC while `busy` is high. The unit is parametrised in operand width and sits beside the ALU, sharing its `srca`/`srcb` operands. The `result` output feeds the writeback mux for mfhi/mflo.

## Interface
Parameters:
- WIDTH, 32, operand, HI and LO width; must be at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; `funct` is valid while `start` is high.
- funct  in  6  R-type function field.
- a  in  WIDTH  operand rs (dividend / multiplicand / mthi, mtlo source).
- b  in  WIDTH  operand rt (divisor / multiplier).
- busy  out  1  operation in progress; reset value 0.
- done  out  1  one-cycle pulse; HI/LO hold the new result in that cycle; reset value 0.
- div_by_zero  out  1  pulses with `done` for div/divu when b==0; reset value 0.
- hi  out  WIDTH  HI register; reset value 0.
- lo  out  WIDTH  LO register; reset value 0.
- result  out  WIDTH  combinational; `hi` for mfhi (010000), `lo` for mflo (010010), else 0.

## Operation
- Decoded functs:
  - mult 011000, multu 011001, div 011010, divu 011011 start a long operation.
  - mthi 010001 and mtlo 010011 write `a` into HI or LO at the next edge. These are single-cycle and do not assert `busy`.
  - mfhi and mflo have no side effects.
  - Any other funct is ignored.
- `start` is accepted only when `busy` is low. A `start` while busy is ignored with no queuing and no error.
- FSM states: IDLE, RUN, FIX.
  - IDLE → RUN on an accepted long op. Operands are latched and converted to magnitudes for signed ops. The counter loads WIDTH-1.
  - RUN: one radix-2 step per cycle. Multiply uses shift-add into a 2·WIDTH accumulator. Divide uses restoring shift-subtract.
  - RUN → FIX when the counter reaches 0 after WIDTH steps.
  - FIX: apply sign correction, write HI/LO, then return to IDLE. `done` is registered, so it is high in the following cycle.
- Multiply result: {HI, LO} is the full 2·WIDTH product.
- Divide result: LO is the quotient truncated toward zero; HI is the remainder, which takes the sign of the dividend.
- Divide by zero: no exception. The raw restoring result is LO = all ones and HI = a, for both signed and unsigned ops. `div_by_zero` is asserted.
- Signed overflow (most-negative ÷ −1): LO = most-negative value, HI = 0.
- mthi or mtlo in the same cycle as `done`: accepted, and the write lands after the long-op result.

## Timing
- Cycle N: `start` high with the unit idle.
- `busy` is high in cycles N+1 … N+WIDTH+1.
- `done` is high only in cycle N+WIDTH+2. `busy` is low in that cycle. HI/LO are updated from that cycle on. Total latency is WIDTH+2 cycles (34 for WIDTH=32).
- A new `start` in the `done` cycle is accepted, giving back-to-back operation.
- `result` is combinational from the HI/LO registers. An mfhi issued in the `done` cycle sees the new value.
- HI/LO are unchanged throughout RUN. An mfhi issued during `busy` returns the old value; the controller must stall it.
- `reset` high at any edge, including mid-operation:
  - FSM goes to IDLE and the counter clears.
  - HI, LO, `busy`, `done` and `div_by_zero` all go to 0.
  - The aborted operation leaves no trace.

## Structure
- Shared package `muldiv_pkg` holds:
  - funct constants: F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO;
  - the state enum {IDLE, RUN, FIX}.
- One natural sub-module, `muldiv_step`: combinational, one iteration of either the shift-add or the shift-subtract step, selected by a mode bit. Parametrised by WIDTH.
- The FSM, counter, sign latch and HI/LO registers live in `muldiv_unit`.

## Test plan
All scenarios use WIDTH=32.
1. mult a=FFFFFFFD, b=00000007 → `done` exactly 34 cycles after `start`; hi=FFFFFFFF, lo=FFFFFFEB; `busy` high for 33 cycles.
2. multu FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001.
3. Signed divide cases:
   - div FFFFFFF9 / 00000002 → lo=FFFFFFFD, hi=FFFFFFFF.
   - div 80000000 / FFFFFFFF → lo=80000000, hi=00000000.
4. divu 00000005 / 0 → lo=FFFFFFFF, hi=00000005, `div_by_zero`=1 only in the `done` cycle.
5. Handshake and reset:
   - mult started, then div `start` at cycle N+5 → ignored; the mult result is correct.
   - `reset` at cycle N+10 → hi=lo=0 and `busy`=0 next cycle, with no `done`.
   - A fresh multu after reset completes correctly.
6. Register moves and back-to-back:
   - mthi a=00001234 → hi=00001234 next cycle with `busy` never high; mfhi `result`=00001234.
   - A multu `start` in a `done` cycle → accepted, with its `done` 34 cycles later.
